// File: rtl/mips_pkg.sv
// Shared CPU constants: register-file geometry and write-back producer indices.
package mips_pkg;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 32;
    localparam logic [ADDR_WIDTH-1:0] ZERO_REG = '0;

    localparam int SRC_ALU  = 0;
    localparam int SRC_LOAD = 1;
    localparam int SRC_MDU  = 2;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant scanning from an internal pointer,
// which moves past the winner whenever the caller signals advance.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_idx;
    logic [PW-1:0] w_next_ptr;
    logic [N-1:0]  w_grant;
    logic          w_found;

    always_comb begin
        w_grant    = '0;
        w_found    = 1'b0;
        w_idx      = '0;
        w_next_ptr = r_ptr;
        for (int k = 0; k < N; k++) begin
            w_idx = PW'((int'(r_ptr) + k) % N);
            if (!w_found && req[w_idx]) begin
                w_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
                w_next_ptr     = PW'((int'(w_idx) + 1) % N);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (advance && w_found) begin
            r_ptr <= w_next_ptr;
        end
    end

    assign grant = w_grant;
endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the single register-file write port: round-robin
// grant, registered write stage, write counter and pending-write hazard mask.
module rf_wb_arbiter
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = mips_pkg::ADDR_WIDTH,
    parameter int NUM_SRC    = SRC_MDU + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC-1:0]            src_valid,
    output logic [NUM_SRC-1:0]            src_ready,
    input  logic [NUM_SRC*ADDR_WIDTH-1:0] src_rd,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    output logic                          rf_we,
    output logic [ADDR_WIDTH-1:0]         rf_rd,
    output logic [DATA_WIDTH-1:0]         rf_data,
    output logic [2**ADDR_WIDTH-1:0]      pending_mask,
    output logic [31:0]                   wr_count
);
    // Handshake: a source's write is taken at the posedge where its
    // src_valid and src_ready are both 1; ready is never raised during rst.

    logic [NUM_SRC-1:0]       w_grant;
    logic [NUM_SRC-1:0]       w_ready;
    logic                     w_take;
    logic [ADDR_WIDTH-1:0]    w_sel_rd;
    logic [DATA_WIDTH-1:0]    w_sel_data;
    logic [2**ADDR_WIDTH-1:0] w_mask;

    logic                     r_we;
    logic [ADDR_WIDTH-1:0]    r_rd;
    logic [DATA_WIDTH-1:0]    r_data;
    logic [31:0]              r_count;

    rr_arbiter #(.N(NUM_SRC)) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (src_valid),
        .advance (w_take),
        .grant   (w_grant)
    );

    assign w_ready = rst ? '0 : w_grant;
    assign w_take  = |w_ready;

    always_comb begin
        w_sel_rd   = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_ready[i]) begin
                w_sel_rd   = w_sel_rd   | src_rd[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_data = w_sel_data | src_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_rd    <= '0;
            r_data  <= '0;
            r_count <= '0;
        end else begin
            // Writes to the zero register complete the handshake but never enable the file.
            if (w_take) begin
                r_we   <= (w_sel_rd != ADDR_WIDTH'(ZERO_REG));
                r_rd   <= w_sel_rd;
                r_data <= w_sel_data;
            end else begin
                r_we   <= 1'b0;
            end
            if (r_we) begin
                r_count <= r_count + 32'd1;
            end
        end
    end

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_valid[i]) begin
                w_mask[src_rd[i*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
            end
        end
        if (r_we) begin
            w_mask[r_rd] = 1'b1;
        end
        w_mask[0] = 1'b0;
    end

    assign src_ready    = w_ready;
    assign rf_we        = r_we;
    assign rf_rd        = r_rd;
    assign rf_data      = r_data;
    assign pending_mask = w_mask;
    assign wr_count     = r_count;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: one task per scenario, inline checks
// against hand-computed values and a small negedge-commit register file.
module tb_rf_wb_arbiter;
    logic        clk;
    logic        rst;
    logic [2:0]  src_valid;
    logic [2:0]  src_ready;
    logic [14:0] src_rd;
    logic [95:0] src_data;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;
    logic [31:0] pending_mask;
    logic [31:0] wr_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] regs [32];

    rf_wb_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .src_valid    (src_valid),
        .src_ready    (src_ready),
        .src_rd       (src_rd),
        .src_data     (src_data),
        .rf_we        (rf_we),
        .rf_rd        (rf_rd),
        .rf_data      (rf_data),
        .pending_mask (pending_mask),
        .wr_count     (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rf_we) regs[rf_rd] <= rf_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic v, input logic [4:0] rd, input logic [31:0] d);
        src_valid[i]       = v;
        src_rd[i*5 +: 5]   = rd;
        src_data[i*32 +: 32] = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        src_valid = '0;
        src_rd = '0;
        src_data = '0;
        step();
        step();
        @(negedge clk);
        n_checks++; if (rf_we !== 1'b0) $display("FAIL reset_we: got %0b want 0", rf_we); else n_pass++;
        n_checks++; if (rf_rd !== 5'd0) $display("FAIL reset_rd: got %0d want 0", rf_rd); else n_pass++;
        n_checks++; if (rf_data !== 32'd0) $display("FAIL reset_data: got %h want 0", rf_data); else n_pass++;
        n_checks++; if (src_ready !== 3'b000) $display("FAIL reset_ready: got %b want 000", src_ready); else n_pass++;
        n_checks++; if (wr_count !== 32'd0) $display("FAIL reset_count: got %0d want 0", wr_count); else n_pass++;
        n_checks++; if (pending_mask !== 32'd0) $display("FAIL reset_mask: got %h want 0", pending_mask); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_single_write();
        step();
        set_src(0, 1'b1, 5'd5, 32'hDEADBEEF);
        @(negedge clk);
        n_checks++; if (src_ready !== 3'b001) $display("FAIL single_ready: got %b want 001", src_ready); else n_pass++;
        n_checks++; if (pending_mask !== 32'h20) $display("FAIL single_mask_req: got %h want 20", pending_mask); else n_pass++;
        step();
        set_src(0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        n_checks++; if (rf_we !== 1'b1) $display("FAIL single_we: got %0b want 1", rf_we); else n_pass++;
        n_checks++; if (rf_rd !== 5'd5) $display("FAIL single_rd: got %0d want 5", rf_rd); else n_pass++;
        n_checks++; if (rf_data !== 32'hDEADBEEF) $display("FAIL single_data: got %h want deadbeef", rf_data); else n_pass++;
        n_checks++; if (pending_mask !== 32'h20) $display("FAIL single_mask_flight: got %h want 20", pending_mask); else n_pass++;
        n_checks++; if (wr_count !== 32'd0) $display("FAIL single_count_early: got %0d want 0", wr_count); else n_pass++;
        step();
        @(negedge clk);
        n_checks++; if (rf_we !== 1'b0) $display("FAIL single_we_drop: got %0b want 0", rf_we); else n_pass++;
        n_checks++; if (wr_count !== 32'd1) $display("FAIL single_count: got %0d want 1", wr_count); else n_pass++;
    endtask

    task automatic test_round_robin();
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_src(0, 1'b1, 5'd1, 32'h100);
        set_src(1, 1'b1, 5'd2, 32'h101);
        set_src(2, 1'b1, 5'd3, 32'h102);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_checks++;
            if (src_ready !== (3'b001 << (k % 3)))
                $display("FAIL rr_ready[%0d]: got %b want %b", k, src_ready, 3'b001 << (k % 3));
            else n_pass++;
            if (k > 0) begin
                n_checks++;
                if (rf_we !== 1'b1 || rf_rd !== 5'((k - 1) % 3 + 1))
                    $display("FAIL rr_rd[%0d]: got we=%0b rd=%0d want we=1 rd=%0d", k, rf_we, rf_rd, (k - 1) % 3 + 1);
                else n_pass++;
            end
            step();
        end
        src_valid = '0;
        @(negedge clk);
        n_checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd3) $display("FAIL rr_rd_last: got we=%0b rd=%0d want we=1 rd=3", rf_we, rf_rd); else n_pass++;
        n_checks++; if (wr_count !== 32'd5) $display("FAIL rr_count_mid: got %0d want 5", wr_count); else n_pass++;
        step();
        @(negedge clk);
        n_checks++; if (wr_count !== 32'd6) $display("FAIL rr_count: got %0d want 6", wr_count); else n_pass++;
    endtask

    task automatic test_zero_reg();
        step();
        set_src(1, 1'b1, 5'd0, 32'h1234);
        @(negedge clk);
        n_checks++; if (src_ready !== 3'b010) $display("FAIL zero_ready: got %b want 010", src_ready); else n_pass++;
        n_checks++; if (pending_mask !== 32'd0) $display("FAIL zero_mask: got %h want 0", pending_mask); else n_pass++;
        step();
        set_src(1, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        n_checks++; if (rf_we !== 1'b0) $display("FAIL zero_we: got %0b want 0", rf_we); else n_pass++;
        n_checks++; if (rf_data !== 32'h1234) $display("FAIL zero_data: got %h want 1234", rf_data); else n_pass++;
        n_checks++; if (pending_mask !== 32'd0) $display("FAIL zero_mask_after: got %h want 0", pending_mask); else n_pass++;
        step();
        @(negedge clk);
        n_checks++; if (wr_count !== 32'd6) $display("FAIL zero_count: got %0d want 6", wr_count); else n_pass++;
    endtask

    task automatic test_collision();
        // A zero-register write from src2 brings the pointer back to 0.
        step();
        set_src(2, 1'b1, 5'd0, 32'd0);
        @(negedge clk);
        n_checks++; if (src_ready !== 3'b100) $display("FAIL coll_align_ready: got %b want 100", src_ready); else n_pass++;
        step();
        set_src(0, 1'b1, 5'd7, 32'hA);
        set_src(2, 1'b1, 5'd7, 32'hB);
        @(negedge clk);
        n_checks++; if (src_ready !== 3'b001) $display("FAIL coll_ready0: got %b want 001", src_ready); else n_pass++;
        n_checks++; if (pending_mask !== 32'h80) $display("FAIL coll_mask: got %h want 80", pending_mask); else n_pass++;
        step();
        set_src(0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        n_checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_data !== 32'hA) $display("FAIL coll_first: got we=%0b rd=%0d data=%h want 1/7/a", rf_we, rf_rd, rf_data); else n_pass++;
        n_checks++; if (src_ready !== 3'b100) $display("FAIL coll_ready2: got %b want 100", src_ready); else n_pass++;
        step();
        set_src(2, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        n_checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_data !== 32'hB) $display("FAIL coll_second: got we=%0b rd=%0d data=%h want 1/7/b", rf_we, rf_rd, rf_data); else n_pass++;
        step();
        step();
        n_checks++; if (regs[7] !== 32'hB) $display("FAIL coll_r7: got %h want b", regs[7]); else n_pass++;
        n_checks++; if (wr_count !== 32'd8) $display("FAIL coll_count: got %0d want 8", wr_count); else n_pass++;
    endtask

    task automatic test_reset_mid();
        set_src(1, 1'b1, 5'd9, 32'h99);
        @(negedge clk);
        n_checks++; if (src_ready !== 3'b010) $display("FAIL rmid_ready: got %b want 010", src_ready); else n_pass++;
        step();
        @(negedge clk);
        n_checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd9) $display("FAIL rmid_staged: got we=%0b rd=%0d want 1/9", rf_we, rf_rd); else n_pass++;
        rst = 1'b1;
        step();
        n_checks++; if (rf_we !== 1'b0) $display("FAIL rmid_we: got %0b want 0", rf_we); else n_pass++;
        n_checks++; if (wr_count !== 32'd0) $display("FAIL rmid_count: got %0d want 0", wr_count); else n_pass++;
        n_checks++; if (src_ready !== 3'b000) $display("FAIL rmid_ready_rst: got %b want 000", src_ready); else n_pass++;
        rst = 1'b0;
        set_src(2, 1'b1, 5'd10, 32'hAA);
        @(negedge clk);
        // Pointer must be back at 0, so src1 beats src2.
        n_checks++; if (src_ready !== 3'b010) $display("FAIL rmid_regrant: got %b want 010", src_ready); else n_pass++;
        step();
        set_src(1, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        n_checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd9 || rf_data !== 32'h99) $display("FAIL rmid_rewrite: got we=%0b rd=%0d data=%h want 1/9/99", rf_we, rf_rd, rf_data); else n_pass++;
        n_checks++; if (src_ready !== 3'b100) $display("FAIL rmid_next: got %b want 100", src_ready); else n_pass++;
        step();
        set_src(2, 1'b0, 5'd0, 32'd0);
        step();
    endtask

    initial begin
        for (int r = 0; r < 32; r++) regs[r] = '0;
        test_reset();
        test_single_write();
        test_round_robin();
        test_zero_reg();
        test_collision();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Write-back arbiter feeding the single write port of the CPU register file (data/rd/we). It collects register-write requests from several producers (ALU, load unit, mult/div unit), grants one per cycle round-robin, and presents a registered write on posedge clk. The register file commits it on the following negedge. It also exports a forwarding copy of the in-flight write and a pending-write mask for hazard detection.

Parameters:
DATA_WIDTH, 32, width of write data
ADDR_WIDTH, 5, register index width (32 registers)
NUM_SRC, 3, number of write-back producers (index 0 = ALU, 1 = load, 2 = mult/div)

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  reset; synchronous, active-high
src_valid  input  NUM_SRC  per-source write request
src_ready  output  NUM_SRC  per-source grant; handshake when valid&ready
src_rd  input  NUM_SRC*ADDR_WIDTH  destination register, source i at [i*ADDR_WIDTH +: ADDR_WIDTH]
src_data  input  NUM_SRC*DATA_WIDTH  write data, source i at [i*DATA_WIDTH +: DATA_WIDTH]
rf_we  output  1  register-file write enable (registered)
rf_rd  output  ADDR_WIDTH  register-file write address (registered)
rf_data  output  DATA_WIDTH  register-file write data (registered)
pending_mask  output  2**ADDR_WIDTH  bit r = a write to r is requested or in flight
wr_count  output  32  number of committed writes, wraps at 2^32

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
- Reset values: rf_we=0, rf_rd=0, rf_data=0, wr_count=0, round-robin pointer=0. While rst=1, src_ready=0 and no handshake occurs.
- Arbitration:
  - Combinational: scan sources starting at the pointer, wrapping mod NUM_SRC.
  - The first source with src_valid=1 gets src_ready=1; all other ready bits are 0.
  - At most one grant per cycle.
- Pointer update: on a grant to source g, the pointer becomes (g+1) mod NUM_SRC at posedge. With no grant, the pointer holds.
- Source rules:
  - A source holds src_valid, src_rd and src_data stable until its handshake.
  - Dropping valid before the grant is a protocol violation; the block's behaviour is then undefined.
  - Throughput is one write per cycle in aggregate; no source waits more than NUM_SRC-1 cycles once valid.
- Output stage (posedge after a grant to g):
  - rf_rd=src_rd[g] and rf_data=src_data[g].
  - rf_we=1 iff src_rd[g]!=0.
  - Writes to $zero are consumed (handshake completes) but never reach the file.
- No grant: rf_we=0; rf_rd and rf_data hold their previous values.
- Latency:
  - Handshake at posedge N gives rf_we=1 during cycle N..N+1.
  - The file commits at the negedge inside that cycle; a read issued at posedge N+1 returns the new value.
- wr_count: increments by 1 at each posedge where rf_we=1 is being presented, i.e. counts cycles with rf_we=1.
- pending_mask (combinational):
  - Bit r (r!=0) = (any src_valid[i] with src_rd[i]==r) OR (rf_we and rf_rd==r).
  - Bit 0 is always 0.
- Same-register collision: two sources targeting the same rd are serviced in grant order. The later grant overwrites; no merging.
- Reset mid-operation: the output stage is cleared (rf_we=0) in the same posedge, so a staged write is discarded. Ungranted requests remain for the sources to re-present after reset.

Decomposition:
- Shared package (mips_pkg): ADDR_WIDTH=5, NUM_REGS=32, ZERO_REG=0, source index constants SRC_ALU=0, SRC_LOAD=1, SRC_MDU=2.
- One sub-module: rr_arbiter.
  - Parameter N; inputs req[N], advance; output one-hot grant[N].
  - Holds the pointer internally; reused later for the memory-port arbiter.
- rf_wb_arbiter instantiates it and adds the output stage, mask logic and counter.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, all valid=0 -> rf_we=0, rf_rd=0, rf_data=0, src_ready=000, wr_count=0, pending_mask=0.
2. Single write: src0 valid, rd=5, data=0xDEADBEEF for 1 cycle -> src_ready=001 that cycle. Next cycle rf_we=1, rf_rd=5, rf_data=0xDEADBEEF; pending_mask bit5=1 on both cycles; wr_count=1 afterwards.
3. Round-robin fairness: all three valid continuously (rd=1,2,3) from pointer 0 -> grants 0,1,2,0,1,2 on consecutive cycles. rf_rd sequence 1,2,3,1,2,3 with rf_we=1 every cycle.
4. Zero register: src1 valid, rd=0, data=0x1234 -> handshake completes; next cycle rf_we=0; wr_count unchanged; pending_mask=0.
5. Same-register collision: src0 rd=7 data=0xA and src2 rd=7 data=0xB together, pointer=0 -> 0xA written, then 0xB; a read of r7 afterwards returns 0xB.
6. Reset mid-operation: grant src1 (rd=9), assert rst on the next posedge -> rf_we=0 at that posedge, wr_count=0, pointer=0. With src1 still valid after reset, it is regranted and rf_rd=9 one cycle later.
